// File: rtl/ps2_pkg.sv
// Shared constants, FSM encoding and event layout for the PS/2
// scan-code decoder.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT  = 8'hE0;
    localparam logic [7:0] PS2_BRK  = 8'hF0;
    localparam logic [7:0] PS2_BAT  = 8'hAA;
    localparam logic [7:0] PS2_ERR0 = 8'h00;
    localparam logic [7:0] PS2_ERR1 = 8'hFF;
    localparam logic [7:0] PS2_ACK  = 8'hFA;
    localparam logic [7:0] PS2_ECHO = 8'hEE;
    localparam logic [7:0] LSHIFT   = 8'h12;
    localparam logic [7:0] RSHIFT   = 8'h59;
    localparam logic [7:0] CTRL     = 8'h14;
    localparam logic [7:0] CAPS     = 8'h58;

    localparam int EVENT_W = 18;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK
    } ps2_state_t;

    typedef struct packed {
        logic [7:0] code;
        logic [7:0] ascii;
        logic       ext;
        logic       rel;
    } ps2_event_t;

    // Bytes that reset the prefix parser without producing an event.
    function automatic logic is_ctl_code(input logic [7:0] b);
        return (b == PS2_ERR0) || (b == PS2_ERR1) ||
               (b == PS2_ACK)  || (b == PS2_ECHO);
    endfunction

endpackage

// File: rtl/ps2_ascii_rom.sv
// Set-2 make code to ASCII lookup; letters honour shift XOR caps,
// other glyphs honour shift only.
module ps2_ascii_rom (
    input  logic [7:0] code,
    input  logic       shift,
    input  logic       caps,
    output logic [7:0] ascii,
    output logic       letter
);
    logic [7:0] base;
    logic [7:0] alt;

    always_comb begin
        base = 8'h00;
        alt  = 8'h00;
        case (code)
            8'h1C: base = 8'h61;
            8'h32: base = 8'h62;
            8'h21: base = 8'h63;
            8'h23: base = 8'h64;
            8'h24: base = 8'h65;
            8'h2B: base = 8'h66;
            8'h34: base = 8'h67;
            8'h33: base = 8'h68;
            8'h43: base = 8'h69;
            8'h3B: base = 8'h6A;
            8'h42: base = 8'h6B;
            8'h4B: base = 8'h6C;
            8'h3A: base = 8'h6D;
            8'h31: base = 8'h6E;
            8'h44: base = 8'h6F;
            8'h4D: base = 8'h70;
            8'h15: base = 8'h71;
            8'h2D: base = 8'h72;
            8'h1B: base = 8'h73;
            8'h2C: base = 8'h74;
            8'h3C: base = 8'h75;
            8'h2A: base = 8'h76;
            8'h1D: base = 8'h77;
            8'h22: base = 8'h78;
            8'h35: base = 8'h79;
            8'h1A: base = 8'h7A;
            8'h45: {base, alt} = {8'h30, 8'h29};
            8'h16: {base, alt} = {8'h31, 8'h21};
            8'h1E: {base, alt} = {8'h32, 8'h40};
            8'h26: {base, alt} = {8'h33, 8'h23};
            8'h25: {base, alt} = {8'h34, 8'h24};
            8'h2E: {base, alt} = {8'h35, 8'h25};
            8'h36: {base, alt} = {8'h36, 8'h5E};
            8'h3D: {base, alt} = {8'h37, 8'h26};
            8'h3E: {base, alt} = {8'h38, 8'h2A};
            8'h46: {base, alt} = {8'h39, 8'h28};
            8'h29: {base, alt} = {8'h20, 8'h20};
            8'h5A: {base, alt} = {8'h0D, 8'h0D};
            8'h66: {base, alt} = {8'h08, 8'h08};
            8'h0D: {base, alt} = {8'h09, 8'h09};
            8'h76: {base, alt} = {8'h1B, 8'h1B};
            8'h0E: {base, alt} = {8'h60, 8'h7E};
            8'h4E: {base, alt} = {8'h2D, 8'h5F};
            8'h55: {base, alt} = {8'h3D, 8'h2B};
            8'h54: {base, alt} = {8'h5B, 8'h7B};
            8'h5B: {base, alt} = {8'h5D, 8'h7D};
            8'h5D: {base, alt} = {8'h5C, 8'h7C};
            8'h4C: {base, alt} = {8'h3B, 8'h3A};
            8'h52: {base, alt} = {8'h27, 8'h22};
            8'h41: {base, alt} = {8'h2C, 8'h3C};
            8'h49: {base, alt} = {8'h2E, 8'h3E};
            8'h4A: {base, alt} = {8'h2F, 8'h3F};
            default: {base, alt} = 16'h0000;
        endcase
    end

    assign letter = (base >= 8'h61) && (base <= 8'h7A);

    always_comb begin
        ascii = base;
        if (letter) begin
            if (shift ^ caps)
                ascii = base - 8'h20;
        end else if (shift) begin
            ascii = alt;
        end
    end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// PS/2 set-2 byte stream to key events: CDC capture, prefix FSM,
// modifier tracking, ASCII translation and an FWFT event FIFO.
module ps2_scancode_decoder
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] event_code,
    output logic [7:0] event_ascii,
    output logic       event_extended,
    output logic       event_release,
    output logic       event_valid,
    input  logic       event_ready,
    output logic       shift_active,
    output logic       ctrl_active,
    output logic       caps_lock,
    output logic       bat_seen,
    output logic       overflow
);
    localparam int PW = $clog2(FIFO_DEPTH);

    logic [SYNC_STAGES-1:0] sync;
    logic [SYNC_STAGES-1:0] fill;
    logic                   sync_q;
    logic                   prev;
    logic                   armed;
    logic                   rise;
    logic [7:0]             byte_q;
    logic                   byte_vld;

    assign sync_q = sync[SYNC_STAGES-1];
    assign rise   = sync_q & ~prev & armed;

    // fill marks when the chain holds real samples, so a level that was
    // already high at reset release cannot arm the capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync     <= '0;
            fill     <= '0;
            prev     <= 1'b0;
            armed    <= 1'b0;
            byte_q   <= '0;
            byte_vld <= 1'b0;
        end else begin
            sync     <= {sync[SYNC_STAGES-2:0], rx_valid};
            fill     <= {fill[SYNC_STAGES-2:0], 1'b1};
            prev     <= sync_q;
            byte_vld <= rise;
            if (fill[SYNC_STAGES-1] && !sync_q)
                armed <= 1'b1;
            if (rise)
                byte_q <= rx_data;
        end
    end

    ps2_state_t state;
    ps2_state_t state_n;
    logic       push;
    logic       bat_hit;
    logic       is_ext;
    logic       is_rel;

    assign is_ext = (state == ST_EXT) || (state == ST_EXT_BRK);
    assign is_rel = (state == ST_BRK) || (state == ST_EXT_BRK);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        push    = 1'b0;
        bat_hit = 1'b0;
        if (byte_vld) begin
            unique case (1'b1)
                (byte_q == PS2_EXT):
                    state_n = (state == ST_IDLE || state == ST_EXT) ?
                              ST_EXT : ST_IDLE;
                (byte_q == PS2_BRK):
                    state_n = (state == ST_IDLE) ? ST_BRK :
                              (state == ST_EXT)  ? ST_EXT_BRK : state;
                (byte_q == PS2_BAT && state == ST_IDLE):
                    bat_hit = 1'b1;
                is_ctl_code(byte_q):
                    state_n = ST_IDLE;
                default: begin
                    push    = 1'b1;
                    state_n = ST_IDLE;
                end
            endcase
        end
    end

    logic       lshift;
    logic       rshift;
    logic       lctrl;
    logic       rctrl;
    logic       caps_held;
    logic [7:0] rom_ascii;
    logic       rom_letter;
    logic [7:0] ev_ascii;
    ps2_event_t ev;

    assign shift_active = lshift | rshift;
    assign ctrl_active  = lctrl | rctrl;

    ps2_ascii_rom u_rom (
        .code   (byte_q),
        .shift  (shift_active),
        .caps   (caps_lock),
        .ascii  (rom_ascii),
        .letter (rom_letter)
    );

    always_comb begin
        ev_ascii = rom_ascii;
        if (is_ext || is_rel)
            ev_ascii = 8'h00;
        else if (ctrl_active && rom_letter)
            ev_ascii = rom_ascii & 8'h1F;
    end

    assign ev = {byte_q, ev_ascii, is_ext, is_rel};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lshift    <= 1'b0;
            rshift    <= 1'b0;
            lctrl     <= 1'b0;
            rctrl     <= 1'b0;
            caps_lock <= 1'b0;
            caps_held <= 1'b0;
            bat_seen  <= 1'b0;
        end else begin
            bat_seen <= bat_hit;
            if (bat_hit) begin
                lshift    <= 1'b0;
                rshift    <= 1'b0;
                lctrl     <= 1'b0;
                rctrl     <= 1'b0;
                caps_lock <= 1'b0;
                caps_held <= 1'b0;
            end else if (push && !is_ext) begin
                if (byte_q == LSHIFT)
                    lshift <= !is_rel;
                if (byte_q == RSHIFT)
                    rshift <= !is_rel;
                if (byte_q == CTRL)
                    lctrl <= !is_rel;
                // Typematic repeats of caps arrive as makes while held.
                if (byte_q == CAPS) begin
                    if (is_rel) begin
                        caps_held <= 1'b0;
                    end else begin
                        caps_held <= 1'b1;
                        if (!caps_held)
                            caps_lock <= !caps_lock;
                    end
                end
            end else if (push && byte_q == CTRL) begin
                rctrl <= !is_rel;
            end
        end
    end

    ps2_event_t    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          full;
    logic          pop;
    logic          wr_en;
    ps2_event_t    head;

    assign full        = (count == (PW+1)'(FIFO_DEPTH));
    assign event_valid = (count != '0);
    assign pop         = event_valid & event_ready;
    assign wr_en       = push & (~full | pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            if (wr_en && !pop)
                count <= count + (PW+1)'(1);
            else if (pop && !wr_en)
                count <= count - (PW+1)'(1);
            if (push && !wr_en)
                overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= ev;
    end

    assign head           = event_valid ? mem[rd_ptr] : '0;
    assign event_code     = head.code;
    assign event_ascii    = head.ascii;
    assign event_extended = head.ext;
    assign event_release  = head.rel;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed bench for ps2_scancode_decoder with a queue scoreboard
// and an independent monitor on the event handshake.
module tb_ps2_scancode_decoder;
    localparam int DEPTH = 8;
    localparam int SYNC  = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] event_code;
    logic [7:0] event_ascii;
    logic       event_extended;
    logic       event_release;
    logic       event_valid;
    logic       event_ready;
    logic       shift_active;
    logic       ctrl_active;
    logic       caps_lock;
    logic       bat_seen;
    logic       overflow;

    int checks   = 0;
    int failures = 0;
    int bat_cnt  = 0;
    logic [17:0] exp_q[$];

    ps2_scancode_decoder #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
        .clk            (clk),
        .reset          (reset),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .event_code     (event_code),
        .event_ascii    (event_ascii),
        .event_extended (event_extended),
        .event_release  (event_release),
        .event_valid    (event_valid),
        .event_ready    (event_ready),
        .shift_active   (shift_active),
        .ctrl_active    (ctrl_active),
        .caps_lock      (caps_lock),
        .bat_seen       (bat_seen),
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic expect_ev(input logic [7:0] code, input logic [7:0] asc,
                             input logic ext, input logic rel);
        exp_q.push_back({code, asc, ext, rel});
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        repeat (6) @(posedge clk);
        #1 rx_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_empty", exp_q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (bat_seen)
            bat_cnt++;
        if (!reset && event_valid && event_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_event actual=%h required=none",
                         {event_code, event_ascii, event_extended,
                          event_release});
            end else begin
                chk("event", {14'd0, event_code, event_ascii,
                              event_extended, event_release},
                    {14'd0, exp_q.pop_front()});
            end
        end
    end

    logic [7:0] ocode [9] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24,
                              8'h2B, 8'h34, 8'h33, 8'h43};
    logic [7:0] oasc  [9] = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65,
                              8'h66, 8'h67, 8'h68, 8'h69};

    initial begin
        int n;
        int b0;
        reset       = 1'b1;
        rx_data     = 8'h00;
        rx_valid    = 1'b0;
        event_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {event_code, event_ascii, event_extended,
                              event_release, event_valid, shift_active,
                              ctrl_active, caps_lock, bat_seen, overflow}, 0);
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;

        // latency and basic make/break
        expect_ev(8'h1C, 8'h61, 1'b0, 1'b0);
        rx_data  = 8'h1C;
        rx_valid = 1'b1;
        n = 0;
        while (!event_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("latency", n, SYNC + 2);
        repeat (4) @(posedge clk);
        #1 rx_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        send(8'hF0);
        expect_ev(8'h1C, 8'h00, 1'b0, 1'b1);
        send(8'h1C);

        // shift
        expect_ev(8'h12, 8'h00, 1'b0, 1'b0);
        send(8'h12);
        chk("shift_on", shift_active, 1);
        expect_ev(8'h1C, 8'h41, 1'b0, 1'b0);
        send(8'h1C);
        expect_ev(8'h16, 8'h21, 1'b0, 1'b0);
        send(8'h16);
        send(8'hF0);
        expect_ev(8'h12, 8'h00, 1'b0, 1'b1);
        send(8'h12);
        chk("shift_off", shift_active, 0);
        expect_ev(8'h1C, 8'h61, 1'b0, 1'b0);
        send(8'h1C);

        // ctrl, left and right
        expect_ev(8'h14, 8'h00, 1'b0, 1'b0);
        send(8'h14);
        chk("lctrl_on", ctrl_active, 1);
        expect_ev(8'h1C, 8'h01, 1'b0, 1'b0);
        send(8'h1C);
        send(8'hF0);
        expect_ev(8'h14, 8'h00, 1'b0, 1'b1);
        send(8'h14);
        chk("lctrl_off", ctrl_active, 0);
        send(8'hE0);
        expect_ev(8'h14, 8'h00, 1'b1, 1'b0);
        send(8'h14);
        chk("rctrl_on", ctrl_active, 1);
        send(8'hE0);
        send(8'hF0);
        expect_ev(8'h14, 8'h00, 1'b1, 1'b1);
        send(8'h14);
        chk("rctrl_off", ctrl_active, 0);

        // caps lock with typematic repeat
        expect_ev(8'h58, 8'h00, 1'b0, 1'b0);
        send(8'h58);
        expect_ev(8'h58, 8'h00, 1'b0, 1'b0);
        send(8'h58);
        chk("caps_once", caps_lock, 1);
        expect_ev(8'h1C, 8'h41, 1'b0, 1'b0);
        send(8'h1C);
        send(8'hF0);
        expect_ev(8'h58, 8'h00, 1'b0, 1'b1);
        send(8'h58);
        chk("caps_kept", caps_lock, 1);
        expect_ev(8'h12, 8'h00, 1'b0, 1'b0);
        send(8'h12);
        expect_ev(8'h1C, 8'h61, 1'b0, 1'b0);
        send(8'h1C);

        // BAT with shift held: clears modifiers, no event
        b0 = bat_cnt;
        send(8'hAA);
        chk("bat_pulse", bat_cnt - b0, 1);
        chk("bat_shift", shift_active, 0);
        chk("bat_caps", caps_lock, 0);

        // extended keys and malformed prefixes
        send(8'hE0);
        expect_ev(8'h75, 8'h00, 1'b1, 1'b0);
        send(8'h75);
        send(8'hE0);
        send(8'hF0);
        expect_ev(8'h75, 8'h00, 1'b1, 1'b1);
        send(8'h75);
        send(8'hF0);
        send(8'hE0);
        expect_ev(8'h1C, 8'h61, 1'b0, 1'b0);
        send(8'h1C);
        send(8'hE0);
        send(8'hFF);
        expect_ev(8'h29, 8'h20, 1'b0, 1'b0);
        send(8'h29);
        drain();

        // overflow
        event_ready = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            if (i < DEPTH)
                expect_ev(ocode[i], oasc[i], 1'b0, 1'b0);
            send(ocode[i]);
        end
        chk("overflow_set", overflow, 1);
        chk("full_valid", event_valid, 1);

        // push and pop together while full
        expect_ev(8'h4B, 8'h6C, 1'b0, 1'b0);
        rx_data  = 8'h4B;
        rx_valid = 1'b1;
        repeat (SYNC + 1) @(posedge clk);
        #1 event_ready = 1'b1;
        @(posedge clk);
        #1 event_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 rx_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1 event_ready = 1'b1;
        drain();

        // reset with queued events and rx_valid high
        event_ready = 1'b0;
        send(8'h12);
        send(8'h1C);
        send(8'h58);
        chk("pre_reset_valid", event_valid, 1);
        chk("pre_reset_shift", shift_active, 1);
        rx_data  = 8'h1C;
        rx_valid = 1'b1;
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("async_reset_outputs", {event_code, event_ascii, event_extended,
                                    event_release, event_valid, shift_active,
                                    ctrl_active, caps_lock, bat_seen,
                                    overflow}, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("no_stale_capture", event_valid, 0);
        event_ready = 1'b1;
        rx_valid    = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        expect_ev(8'h1C, 8'h61, 1'b0, 1'b0);
        send(8'h1C);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ps2_scancode_decoder.md
Name: ps2_scancode_decoder

Overview:
- Consumes raw bytes from the PS/2 receiver stage (ps2_clk domain) and moves them into the system clk domain.
- Parses set-2 prefixes (E0/F0), tracks modifiers and translates make codes to ASCII.
- Pushes key events into a small FIFO with a valid/ready output handshake for the CPU-side keyboard interface.

Parameters:
- FIFO_DEPTH, 8, event FIFO entries; must be a power of 2, minimum 2.
- SYNC_STAGES, 2, flops in the rx_valid synchronizer; minimum 2.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- rx_data  in  8  received byte from the receiver, LSB-first corrected; stable while rx_valid is high
- rx_valid  in  1  receiver frame-complete flag, ps2_clk domain (asynchronous to clk)
- event_code  out  8  scan code of the head event
- event_ascii  out  8  ASCII of the head event; 0x00 when not printable
- event_extended  out  1  head event was E0-prefixed
- event_release  out  1  head event was F0-prefixed (break)
- event_valid  out  1  FIFO non-empty
- event_ready  in  1  consumer accepts the head event
- shift_active  out  1  left or right shift held
- ctrl_active  out  1  left or right ctrl held
- caps_lock  out  1  caps lock toggle state
- bat_seen  out  1  one-cycle pulse on keyboard self-test pass (0xAA)
- overflow  out  1  sticky: an event was dropped because the FIFO was full

Behaviour:
- Reset (async assert, sync release) clears all state:
  - sync flops = 0, FSM = IDLE, FIFO empty.
  - All outputs = 0, modifier state = 0, overflow = 0, armed = 0.
- Capture:
  - rx_valid passes through SYNC_STAGES flops; a rising edge of the synced signal while armed captures rx_data into a byte register.
  - armed sets once synced rx_valid is seen low, so rx_valid already high at reset release is ignored.
- FSM states: IDLE, EXT, BRK, EXT_BRK. Transitions on each captured byte:
  - 0xE0: IDLE->EXT; EXT stays EXT; BRK->IDLE (malformed, dropped); EXT_BRK->IDLE (malformed, dropped).
  - 0xF0: IDLE->BRK; EXT->EXT_BRK; BRK and EXT_BRK stay.
  - 0xAA in IDLE: pulse bat_seen; clear shift/ctrl/caps; no event. 0xAA in any other state is an ordinary code.
  - 0x00 or 0xFF (keyboard error), 0xFA (ack), 0xEE (echo): go to IDLE, no event.
  - Any other byte: push an event {code, ascii, extended = state in EXT/EXT_BRK, release = state in BRK/EXT_BRK}, then go to IDLE.
- Modifiers, updated in the push cycle:
  - 0x12 and 0x59 (non-extended) drive left/right shift.
  - 0x14 drives left ctrl; E0 0x14 drives right ctrl.
  - 0x58 make toggles caps_lock only if caps is not already held; typematic repeats do not toggle. 0x58 break clears the held flag.
- ASCII, from the ROM plus the modifier state before this event's update:
  - 0x00 for release, extended and modifier-key events.
  - Letters: uppercase when shift XOR caps_lock.
  - Other printables: shifted glyph when shift is held.
  - With ctrl held, letters give uppercase & 0x1F.
- Latency: with the FIFO empty, event_valid rises exactly SYNC_STAGES+2 clk edges after the first edge that samples rx_valid high.
- FIFO:
  - First-word-fall-through; pop when event_valid && event_ready.
  - Push while full and not popping: new event dropped, overflow set (sticky until reset), FIFO contents unchanged.
  - Push and pop in the same cycle while full: both happen.
  - Push and pop in the same cycle while empty: not possible (head not yet visible).
  - Pointers wrap modulo FIFO_DEPTH; a count register distinguishes full from empty.
- Reset mid-frame or mid-prefix drops the partial sequence; no event is produced.

Decomposition:
- Package ps2_pkg:
  - Code constants: PS2_EXT=0xE0, PS2_BRK=0xF0, PS2_BAT=0xAA, PS2_ERR0=0x00, PS2_ERR1=0xFF, PS2_ACK=0xFA, PS2_ECHO=0xEE, LSHIFT=0x12, RSHIFT=0x59, CTRL=0x14, CAPS=0x58.
  - FSM state encoding.
  - Event field width (18 bits: code, ascii, extended, release).
- Sub-module ps2_ascii_rom: combinational, (code, shift, caps) -> ascii, covering letters, digits, space 0x29, enter 0x5A, backspace 0x66 and punctuation.

Test Plan:
- 0x1C then 0xF0,0x1C with ready=1 -> two events {1C,'a'=0x61,ext=0,rel=0} and {1C,0x00,0,1}; event_valid first rises SYNC_STAGES+2 edges after the first edge that samples rx_valid high.
- 0x12, 0x1C, 0xF0,0x12, 0x1C -> shift_active 1 then 0; 'a' events give ascii 0x41 then 0x61. 0x58 make twice (repeat) -> caps_lock=1 once; 0x1C -> 0x41.
- 0xE0,0x75 then 0xE0,0xF0,0x75 -> {75,00,ext=1,rel=0}, {75,00,ext=1,rel=1}. 0xF0,0xE0 -> FSM IDLE, no event.
- ready=0, FIFO_DEPTH+1 make codes -> FIFO_DEPTH events retained in order, overflow=1. With FIFO full, ready=1 plus a simultaneous push -> no further drop.
- 0xAA with shift held -> bat_seen one-cycle pulse, shift_active=0, no event. 0xFF after 0xE0 -> IDLE, no event.
- Assert reset while rx_valid is high and 3 events are queued -> all outputs 0 immediately. Deassert with rx_valid still high -> no capture until rx_valid toggles low then high.
